// File: rtl/dsp_preadd_pair.sv
// dsp_preadd_pair: pipelined exact pre-adder (P = A + D) and modular 21-bit adder sharing clock, enable and reset
module dsp_preadd_pair #(
  parameter int DSP_LATENCY = 3,
  parameter int ADD_LATENCY = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CE,
  input  logic [18:0] A,
  input  logic [18:0] D,
  output logic [19:0] P,
  input  logic [20:0] ADD_A,
  input  logic [20:0] ADD_C,
  output logic [20:0] ADD_P
);
  if (DSP_LATENCY < 1 || DSP_LATENCY > 8) begin : g_bad_dsp
    $error("dsp_preadd_pair: DSP_LATENCY must be in 1..8");
  end
  if (ADD_LATENCY < 1 || ADD_LATENCY > 8) begin : g_bad_add
    $error("dsp_preadd_pair: ADD_LATENCY must be in 1..8");
  end
  if (DSP_LATENCY == 1) begin : g_p1
    // single stage: the sum lands directly in the output register
    always_ff @(posedge CLK or posedge RST)
      if (RST) P <= '0;
      else if (CE) P <= {1'b0, A} + {1'b0, D};
  end else begin : g_pn
    logic [18:0] a_q, d_q;
    logic [19:0] s_q [DSP_LATENCY:2];
    // operand capture, sum into stage 2, then a plain delay line
    always_ff @(posedge CLK or posedge RST)
      if (RST) begin
        a_q <= '0;
        d_q <= '0;
        for (int i = 2; i <= DSP_LATENCY; i++) s_q[i] <= '0;
      end else if (CE) begin
        a_q <= A;
        d_q <= D;
        s_q[2] <= {1'b0, a_q} + {1'b0, d_q};
        for (int i = 3; i <= DSP_LATENCY; i++) s_q[i] <= s_q[i-1];
      end
    assign P = s_q[DSP_LATENCY];
  end
  logic [20:0] r_q [ADD_LATENCY:1];
  // wrapping sum registered on the first stage, remaining stages delay it
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      for (int i = 1; i <= ADD_LATENCY; i++) r_q[i] <= '0;
    end else if (CE) begin
      r_q[1] <= ADD_A + ADD_C;
      for (int i = 2; i <= ADD_LATENCY; i++) r_q[i] <= r_q[i-1];
    end
  assign ADD_P = r_q[ADD_LATENCY];
endmodule

// File: tb/tb_dsp_preadd_pair.sv
// tb_dsp_preadd_pair: scoreboard bench for dsp_preadd_pair at three latency settings
module tb_dsp_preadd_pair;
  logic CLK = 1'b0;
  logic RST, CE;
  logic [18:0] A, D;
  logic [20:0] ADD_A, ADD_C;
  logic [19:0] p3, p1, p5;
  logic [20:0] ap1, ap8, ap3;
  logic [19:0] qp3[$], qp1[$], qp5[$];
  logic [20:0] qa1[$], qa8[$], qa3[$];
  logic [19:0] ep3, ep1, ep5;
  logic [20:0] ea1, ea8, ea3;
  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  dsp_preadd_pair u3 (
    .CLK(CLK), .RST(RST), .CE(CE), .A(A), .D(D), .P(p3),
    .ADD_A(ADD_A), .ADD_C(ADD_C), .ADD_P(ap1)
  );
  dsp_preadd_pair #(.DSP_LATENCY(1), .ADD_LATENCY(8)) u1 (
    .CLK(CLK), .RST(RST), .CE(CE), .A(A), .D(D), .P(p1),
    .ADD_A(ADD_A), .ADD_C(ADD_C), .ADD_P(ap8)
  );
  dsp_preadd_pair #(.DSP_LATENCY(5), .ADD_LATENCY(3)) u5 (
    .CLK(CLK), .RST(RST), .CE(CE), .A(A), .D(D), .P(p5),
    .ADD_A(ADD_A), .ADD_C(ADD_C), .ADD_P(ap3)
  );

  task automatic init_q();
    qp3.delete(); qp1.delete(); qp5.delete();
    qa1.delete(); qa8.delete(); qa3.delete();
    repeat (2) qp3.push_back('0);
    repeat (4) qp5.push_back('0);
    repeat (7) qa8.push_back('0);
    repeat (2) qa3.push_back('0);
    ep3 = '0; ep1 = '0; ep5 = '0; ea1 = '0; ea8 = '0; ea3 = '0;
  endtask

  task automatic drive(input logic [18:0] a, input logic [18:0] d, input logic [20:0] x, input logic [20:0] y);
    A = a; D = d; ADD_A = x; ADD_C = y;
  endtask

  task automatic tick();
    logic [19:0] sp;
    logic [20:0] sa;
    logic ce_s;
    sp = {1'b0, A} + {1'b0, D};
    sa = ADD_A + ADD_C;
    ce_s = CE;
    if (ce_s) begin
      qp3.push_back(sp); qp1.push_back(sp); qp5.push_back(sp);
      qa1.push_back(sa); qa8.push_back(sa); qa3.push_back(sa);
    end
    @(posedge CLK);
    #1;
    if (ce_s) begin
      ep3 = qp3.pop_front(); ep1 = qp1.pop_front(); ep5 = qp5.pop_front();
      ea1 = qa1.pop_front(); ea8 = qa8.pop_front(); ea3 = qa3.pop_front();
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; CE = 1'b0;
    drive(19'h0, 19'h0, 21'h0, 21'h0);
    #2;
    checks++;
    if (p3 !== 20'h0) begin errors++; $display("FAIL reset_p got %h exp %h", p3, 20'h0); end
    checks++;
    if (ap1 !== 21'h0) begin errors++; $display("FAIL reset_addp got %h exp %h", ap1, 21'h0); end
    @(posedge CLK);
    #1;
    RST = 1'b0; CE = 1'b1;
    init_q();
  endtask

  task automatic test_preadd_directed();
    logic [18:0] ta [4] = '{19'h434, 19'h222, 19'h522, 19'h422};
    logic [18:0] td [4] = '{19'h234, 19'h333, 19'h433, 19'h363};
    logic [19:0] tp [4] = '{20'h668, 20'h555, 20'h955, 20'h785};
    for (int j = 0; j < 7; j++) begin
      if (j < 4) drive(ta[j], td[j], 21'h0, 21'h0);
      else drive(19'h0, 19'h0, 21'h0, 21'h0);
      tick();
      checks++;
      if (p3 !== ep3) begin errors++; $display("FAIL preadd_sb[%0d] got %h exp %h", j, p3, ep3); end
      if (j >= 2 && j < 6) begin
        checks++;
        if (p3 !== tp[j-2]) begin errors++; $display("FAIL preadd_dir[%0d] got %h exp %h", j, p3, tp[j-2]); end
      end
    end
  endtask

  task automatic test_preadd_extreme();
    logic [19:0] tp [5] = '{20'h0, 20'h0, 20'hFFFFE, 20'h0, 20'h2};
    for (int j = 0; j < 5; j++) begin
      if (j == 0) drive(19'h7FFFF, 19'h7FFFF, 21'h0, 21'h0);
      else if (j == 2) drive(19'h1, 19'h1, 21'h0, 21'h0);
      else drive(19'h0, 19'h0, 21'h0, 21'h0);
      tick();
      checks++;
      if (p3 !== tp[j]) begin errors++; $display("FAIL preadd_ext[%0d] got %h exp %h", j, p3, tp[j]); end
      checks++;
      if (p1 !== ep1) begin errors++; $display("FAIL preadd_ext_l1[%0d] got %h exp %h", j, p1, ep1); end
    end
  endtask

  task automatic test_adder_wrap();
    logic [20:0] tx [4] = '{21'h434, 21'h1FFFFF, 21'h1FFFFF, 21'h0};
    logic [20:0] ty [4] = '{21'h234, 21'h1, 21'h1FFFFF, 21'h0};
    logic [20:0] tr [4] = '{21'h668, 21'h0, 21'h1FFFFE, 21'h0};
    for (int j = 0; j < 4; j++) begin
      drive(19'h0, 19'h0, tx[j], ty[j]);
      tick();
      checks++;
      if (ap1 !== tr[j]) begin errors++; $display("FAIL add_dir[%0d] got %h exp %h", j, ap1, tr[j]); end
      checks++;
      if (ap1 !== ea1) begin errors++; $display("FAIL add_sb[%0d] got %h exp %h", j, ap1, ea1); end
    end
  endtask

  task automatic test_ce_stall();
    logic [19:0] hp;
    logic [20:0] ha;
    drive(19'h434, 19'h234, 21'h434, 21'h234);
    tick();
    drive(19'h222, 19'h333, 21'h222, 21'h333);
    tick();
    hp = p3; ha = ap1;
    CE = 1'b0;
    for (int j = 0; j < 4; j++) begin
      drive(19'($urandom), 19'($urandom), 21'($urandom), 21'($urandom));
      tick();
      checks++;
      if (p3 !== hp) begin errors++; $display("FAIL stall_p[%0d] got %h exp %h", j, p3, hp); end
      checks++;
      if (ap1 !== ha) begin errors++; $display("FAIL stall_addp[%0d] got %h exp %h", j, ap1, ha); end
    end
    CE = 1'b1;
    drive(19'h0, 19'h0, 21'h0, 21'h0);
    for (int j = 0; j < 3; j++) begin
      tick();
      checks++;
      if (p3 !== ep3) begin errors++; $display("FAIL stall_sb[%0d] got %h exp %h", j, p3, ep3); end
      if (j < 2) begin
        checks++;
        if (p3 !== (j == 0 ? 20'h668 : 20'h555)) begin
          errors++; $display("FAIL stall_order[%0d] got %h exp %h", j, p3, (j == 0 ? 20'h668 : 20'h555));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    drive(19'h1234, 19'h4321, 21'h12345, 21'h54321);
    repeat (6) tick();
    #3;
    RST = 1'b1;
    #1;
    checks++;
    if ({p3, p1, p5} !== 60'h0) begin errors++; $display("FAIL rst_async_p got %h %h %h exp 0", p3, p1, p5); end
    checks++;
    if ({ap1, ap8, ap3} !== 63'h0) begin errors++; $display("FAIL rst_async_addp got %h %h %h exp 0", ap1, ap8, ap3); end
    @(posedge CLK);
    #1;
    RST = 1'b0;
    init_q();
    drive(19'h10, 19'h20, 21'h40, 21'h80);
    for (int j = 0; j < 4; j++) begin
      tick();
      checks++;
      if (p3 !== (j >= 2 ? 20'h30 : 20'h0)) begin errors++; $display("FAIL rst_refill_p[%0d] got %h exp %h", j, p3, (j >= 2 ? 20'h30 : 20'h0)); end
      checks++;
      if (ap3 !== ea3) begin errors++; $display("FAIL rst_refill_add3[%0d] got %h exp %h", j, ap3, ea3); end
    end
  endtask

  task automatic test_back_to_back();
    for (int j = 0; j < 1000; j++) begin
      if (j < 500) drive(19'($urandom), 19'($urandom), 21'($urandom), 21'($urandom));
      else drive(19'($urandom), 19'($urandom), 21'h1FFFF0, 21'h20);
      tick();
      checks++;
      if (p1 !== ep1) begin errors++; $display("FAIL b2b_p_l1[%0d] got %h exp %h", j, p1, ep1); end
      checks++;
      if (p5 !== ep5) begin errors++; $display("FAIL b2b_p_l5[%0d] got %h exp %h", j, p5, ep5); end
      checks++;
      if (p3 !== ep3) begin errors++; $display("FAIL b2b_p_l3[%0d] got %h exp %h", j, p3, ep3); end
      checks++;
      if (ap1 !== ea1) begin errors++; $display("FAIL b2b_add_l1[%0d] got %h exp %h", j, ap1, ea1); end
      checks++;
      if (ap8 !== ea8) begin errors++; $display("FAIL b2b_add_l8[%0d] got %h exp %h", j, ap8, ea8); end
      checks++;
      if (ap3 !== ea3) begin errors++; $display("FAIL b2b_add_l3[%0d] got %h exp %h", j, ap3, ea3); end
    end
  endtask

  initial begin
    test_reset();
    test_preadd_directed();
    test_preadd_extreme();
    test_adder_wrap();
    test_ce_stall();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dsp_preadd_pair.md
Name: dsp_preadd_pair

Overview:
- Dual unsigned adder block: a DSP48-style pre-adder path (P = A + D, full-width result) and a modular 21-bit adder path (ADD_P = ADD_A + ADD_C mod 2^21).
- Used in the FFT datapath where twiddle/butterfly operands are summed before downstream multiply/normalise stages.
- Both paths are fully pipelined, share one clock, one clock enable and one reset.

Parameters:
- DSP_LATENCY, 3, register stages from A/D to P; legal range 1..8.
- ADD_LATENCY, 1, register stages from ADD_A/ADD_C to ADD_P; legal range 1..8.

Ports:
- CLK  input  1  system clock, all registers rising-edge.
- RST  input  1  asynchronous, active-high reset of every pipeline register.
- CE  input  1  clock enable for both pipelines; 0 freezes all registers.
- A  input  19  pre-adder operand, unsigned.
- D  input  19  pre-adder operand, unsigned.
- P  output  20  A + D, unsigned, no truncation.
- ADD_A  input  21  adder operand, unsigned.
- ADD_C  input  21  adder operand, unsigned.
- ADD_P  output  21  (ADD_A + ADD_C) mod 2^21.

Behaviour:
- Reset: RST high forces every pipeline register to 0 immediately, independent of CLK and CE. P = 0 and ADD_P = 0 while RST is high and until valid data propagates afterwards.
- Reset mid-operation: all in-flight results are discarded. The first non-zero output after RST falls appears DSP_LATENCY (or ADD_LATENCY) enabled edges after the first sampled input.
- Pre-adder path:
  - Operands are zero-extended to 20 bits and summed. The 20-bit result is always exact; the maximum 0x7FFFF + 0x7FFFF = 0xFFFFE never overflows.
  - The input is registered on the first enabled edge. The sum is formed between stage 1 and stage 2 (combinational, or in the output register if DSP_LATENCY = 1).
  - The remaining stages are a delay line.
  - P equals the sum of the operands sampled DSP_LATENCY enabled edges earlier.
- Adder path:
  - Operands are summed as 22 bits and the carry-out is discarded. The result wraps modulo 2^21, with no overflow flag.
  - ADD_P equals the sum of operands sampled ADD_LATENCY enabled edges earlier.
- CE low: no register updates in either path and outputs hold. Latency is counted in enabled edges only.
- Throughput: one new operand pair per enabled cycle per path. The paths are independent, so changing one path's inputs never affects the other path's output.
- Inputs changing every cycle: each result corresponds exactly to its own input sample, with no blending across stages.
- Outputs are driven directly from registers; there is no combinational input-to-output path.
- Illegal parameter values (outside 1..8) must be rejected at elaboration.

Test Plan:
- Reset: assert RST asynchronously mid-stream with CE = 1 -> P and ADD_P go to 0 without waiting for a clock edge; after release, outputs stay 0 until the new data has traversed the pipeline.
- Pre-adder directed, default latency: A = 0x434, D = 0x234 -> P = 0x668 three edges later. Then apply in turn:
  - 0x222 + 0x333 -> P = 0x555
  - 0x522 + 0x433 -> P = 0x955
  - 0x422 + 0x363 -> P = 0x785
- Pre-adder extreme: A = D = 0x7FFFF -> P = 0xFFFFE. A = D = 0 -> P = 0.
- Adder directed and wrap: ADD_A = 0x434, ADD_C = 0x234 -> ADD_P = 0x668 after one edge. ADD_A = 0x1FFFFF, ADD_C = 0x1 -> ADD_P = 0x000000. ADD_A = ADD_C = 0x1FFFFF -> ADD_P = 0x1FFFFE.
- CE stall: feed the sequence 0x434/0x234 then 0x222/0x333, and drop CE for 4 cycles mid-pipeline -> outputs hold during the stall, and results 0x668 then 0x555 emerge in order after CE returns, with the latency counted in enabled edges.
- Back-to-back random: 1000 random operand pairs per path, one per cycle, with DSP_LATENCY = 1 and then 5 -> every output matches the reference model at the exact latency, and the two paths are independent.
